// File: rtl/lzrw1_job_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : lzrw1_job_sequencer_if
// Purpose  : Job, byte-stream and core-side signal bundle of the LZRW1 job sequencer
// Revision : 1.0
// ============================================================================
interface lzrw1_job_sequencer_if #(
  parameter int STRINGSIZE = 4096
);
  localparam int LW = $clog2(STRINGSIZE) + 1;

  logic             start;
  logic [LW-1:0]    src_len;
  logic             busy;
  logic             job_done;
  logic             job_err;

  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;

  logic             core_clear;
  logic             core_valid;
  logic [15:0][7:0] core_bytes;
  logic             core_done;
  logic [31:0]      core_count;
  logic [LW-2:0]    core_rd_idx;
  logic [7:0]       core_rd_byte;
  logic             core_rd_ctl;

  logic [LW-1:0]    comp_len;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_ctl;
  logic             out_last;

  // The sequencer is the slave of this bundle; the system/core side is the master.
  modport slave (
    input  start, src_len, in_valid, in_data, core_done, core_count,
           core_rd_byte, core_rd_ctl, out_ready,
    output busy, job_done, job_err, in_ready, core_clear, core_valid,
           core_bytes, core_rd_idx, comp_len, out_valid, out_data, out_ctl, out_last
  );

  modport master (
    output start, src_len, in_valid, in_data, core_done, core_count,
           core_rd_byte, core_rd_ctl, out_ready,
    input  busy, job_done, job_err, in_ready, core_clear, core_valid,
           core_bytes, core_rd_idx, comp_len, out_valid, out_data, out_ctl, out_last
  );
endinterface
`default_nettype wire

// File: rtl/lzrw1_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lzrw1_job_sequencer
// Purpose  : Sequences one LZRW1 pass: load 16-byte beats, await core Done, drain result
// Revision : 1.0
// ============================================================================
module lzrw1_job_sequencer #(
  parameter int STRINGSIZE     = 4096,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                 clock,
  input  logic                 reset,
  lzrw1_job_sequencer_if.slave bus
);
  localparam int LW = $clog2(STRINGSIZE) + 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [LW-1:0] c_MAX_LEN   = LW'(STRINGSIZE);
  localparam logic [LW-1:0] c_LEN_ONE   = LW'(1);
  localparam logic [LW-2:0] c_IDX_ONE   = (LW-1)'(1);
  localparam logic [TW-1:0] c_TIMER_END = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] c_TIMER_ONE = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_ISSUE = 3'd3,
    S_RUN   = 3'd4,
    S_DRAIN = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  state_t           r_state;
  logic [LW-1:0]    r_src_len;
  logic [LW-1:0]    r_byte_cnt;
  logic [4:0]       r_lane_cnt;
  logic [15:0][7:0] r_beat;
  logic [TW-1:0]    r_timer;
  logic [LW-2:0]    r_rd_idx;
  logic [LW-1:0]    r_comp_len;
  logic             r_busy;
  logic             r_job_done;
  logic             r_job_err;
  logic             r_in_ready;
  logic             r_core_clear;
  logic             r_core_valid;
  logic             r_out_valid;

  logic             w_in_hs;
  logic             w_out_hs;
  logic             w_last;
  logic [LW-1:0]    w_byte_cnt_nxt;
  logic [LW-1:0]    w_clamped_len;

  assign w_in_hs        = r_in_ready & bus.in_valid;
  assign w_out_hs       = r_out_valid & bus.out_ready;
  assign w_last         = ({1'b0, r_rd_idx} == (r_comp_len - c_LEN_ONE));
  assign w_byte_cnt_nxt = r_byte_cnt + c_LEN_ONE;
  // The core may report more entries than its arrays hold; never drain past them.
  assign w_clamped_len  = (bus.core_count > 32'(STRINGSIZE)) ? c_MAX_LEN
                                                             : bus.core_count[LW-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_src_len    <= '0;
      r_byte_cnt   <= '0;
      r_lane_cnt   <= '0;
      r_beat       <= '0;
      r_timer      <= '0;
      r_rd_idx     <= '0;
      r_comp_len   <= '0;
      r_busy       <= 1'b0;
      r_job_done   <= 1'b0;
      r_job_err    <= 1'b0;
      r_in_ready   <= 1'b0;
      r_core_clear <= 1'b0;
      r_core_valid <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      r_core_clear <= 1'b0;
      r_core_valid <= 1'b0;
      r_job_done   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_busy <= 1'b1;
            if (bus.src_len == '0) begin
              r_job_err  <= 1'b0;
              r_job_done <= 1'b1;
              r_state    <= S_FIN;
            end else if (bus.src_len > c_MAX_LEN) begin
              r_job_err  <= 1'b1;
              r_job_done <= 1'b1;
              r_state    <= S_FIN;
            end else begin
              r_src_len    <= bus.src_len;
              r_job_err    <= 1'b0;
              r_core_clear <= 1'b1;
              r_state      <= S_CLEAR;
            end
          end
        end

        S_CLEAR: begin
          r_byte_cnt <= '0;
          r_lane_cnt <= '0;
          r_beat     <= '0;
          r_in_ready <= 1'b1;
          r_state    <= S_LOAD;
        end

        S_LOAD: begin
          if (w_in_hs) begin
            r_beat[r_lane_cnt[3:0]] <= bus.in_data;
            r_lane_cnt              <= r_lane_cnt + 5'd1;
            r_byte_cnt              <= w_byte_cnt_nxt;
            // Leave on the filling handshake itself so a full beat costs 16+1 cycles.
            if ((r_lane_cnt == 5'd15) || (w_byte_cnt_nxt == r_src_len)) begin
              r_in_ready   <= 1'b0;
              r_core_valid <= 1'b1;
              r_state      <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          if (r_byte_cnt == r_src_len) begin
            r_timer <= '0;
            r_state <= S_RUN;
          end else begin
            r_lane_cnt <= '0;
            r_beat     <= '0;
            r_in_ready <= 1'b1;
            r_state    <= S_LOAD;
          end
        end

        S_RUN: begin
          r_timer <= r_timer + c_TIMER_ONE;
          if (bus.core_done) begin
            r_comp_len <= w_clamped_len;
            r_rd_idx   <= '0;
            if (w_clamped_len == '0) begin
              r_job_done <= 1'b1;
              r_state    <= S_FIN;
            end else begin
              r_out_valid <= 1'b1;
              r_state     <= S_DRAIN;
            end
          end else if (r_timer == c_TIMER_END) begin
            r_job_err  <= 1'b1;
            r_job_done <= 1'b1;
            r_state    <= S_FIN;
          end
        end

        S_DRAIN: begin
          if (w_out_hs) begin
            if (w_last) begin
              r_out_valid <= 1'b0;
              r_rd_idx    <= '0;
              r_job_done  <= 1'b1;
              r_state     <= S_FIN;
            end else begin
              r_rd_idx <= r_rd_idx + c_IDX_ONE;
            end
          end
        end

        S_FIN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.job_done    = r_job_done;
  assign bus.job_err     = r_job_err;
  assign bus.in_ready    = r_in_ready;
  assign bus.core_clear  = r_core_clear;
  assign bus.core_valid  = r_core_valid;
  assign bus.core_bytes  = r_beat;
  assign bus.comp_len    = r_comp_len;
  assign bus.out_valid   = r_out_valid;
  assign bus.core_rd_idx = r_out_valid ? r_rd_idx : '0;
  assign bus.out_data    = r_out_valid ? bus.core_rd_byte : 8'h00;
  assign bus.out_ctl     = r_out_valid & bus.core_rd_ctl;
  assign bus.out_last    = r_out_valid & w_last;
endmodule
`default_nettype wire

// File: tb/tb_lzrw1_job_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_lzrw1_job_sequencer
// Purpose  : Job-level table, corner-case and random bench for lzrw1_job_sequencer
// Revision : 1.0
// ============================================================================
module tb_lzrw1_job_sequencer;
  localparam int SS     = 64;
  localparam int TO     = 64;
  localparam int LW     = $clog2(SS) + 1;
  localparam int BUDGET = 2000;

  typedef struct {
    int len;
    int cnt;
    bit gd;
    int rm;
    int vm;
    bit err;
    int beats;
    int clen;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  lzrw1_job_sequencer_if #(.STRINGSIZE(SS)) bus ();

  lzrw1_job_sequencer #(.STRINGSIZE(SS), .TIMEOUT_CYCLES(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0]    src  [128];
  logic [7:0]    cmem [SS];
  logic          cctl [SS];
  logic [127:0]  got  [8];
  logic [LW+8:0] w_snap;
  int            nvec;
  int            nmis;
  int            model_clen;
  vec_t          tbl [8];

  // Core result arrays are read combinationally through the index mux.
  assign bus.core_rd_byte = cmem[bus.core_rd_idx];
  assign bus.core_rd_ctl  = cctl[bus.core_rd_idx];
  assign w_snap = {bus.core_rd_idx, bus.out_data, bus.out_ctl, bus.out_last};

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  // Beat b of a source of len bytes: 16 consecutive bytes, lane 0 first, zero past the end.
  function automatic logic [127:0] exp_beat(int len, int b);
    logic [127:0] v = '0;
    for (int j = 0; j < 16; j++)
      if (b * 16 + j < len) v[8*j +: 8] = src[b * 16 + j];
    return v;
  endfunction

  task automatic run_job(input int len, input int count, input bit give_done, input int rdy_mode,
                         input int vld_mode, input bit exp_err, input int exp_beats,
                         input int exp_clen, input bit start_in_load, input bit rst_in_drain);
    int cyc, idx, nb, nclr, nout, first_rdy, first_out, last_vld, last_hs, done_at, done_cyc;
    int busy_err, stall_err, idle_err, drain_n, jd, bz;
    bit tog, stalled, pulsed, rdy;
    logic [LW+8:0] prev, e;
    for (int i = 0; i < 128; i++) src[i] = 8'($urandom);
    for (int i = 0; i < SS; i++) begin
      cmem[i] = 8'($urandom);
      cctl[i] = 1'($urandom);
    end
    for (int i = 0; i < 8; i++) got[i] = 'x;
    cyc = 0; idx = 0; nb = 0; nclr = 0; nout = 0;
    first_rdy = -1; first_out = -1; last_vld = -1; last_hs = -1; done_at = -1; done_cyc = -1;
    busy_err = 0; stall_err = 0; idle_err = 0;
    tog = 1'b1; stalled = 1'b0; pulsed = 1'b0; prev = '0;
    drain_n = (give_done && exp_beats > 0) ? exp_clen : 0;
    bus.core_count = 32'(count);

    bus.start   = 1'b1;
    bus.src_len = LW'(len);
    @(posedge clock); #1;
    cyc = 1;
    while (done_cyc < 0 && cyc < BUDGET) begin
      bus.start = 1'b0;
      if (cyc == 1) begin
        chk("err_at_accept", 128'(bus.job_err), 128'(len > SS));
        chk("clear_latency", 128'(bus.core_clear), 128'(exp_beats > 0));
      end
      if (!bus.busy) busy_err++;
      if (bus.core_clear) nclr++;
      if (bus.in_ready && first_rdy < 0) first_rdy = cyc;
      if (bus.core_valid) begin
        if (nb < 8) got[nb] = bus.core_bytes;
        nb++;
        last_vld = cyc;
        if (give_done && idx == len && done_at < 0) done_at = cyc + 1 + int'($urandom_range(0, 3));
      end
      bus.core_done = (done_at >= 0 && cyc >= done_at);

      if (bus.out_valid) begin
        if (first_out < 0) first_out = cyc;
        if (stalled && prev !== w_snap) stall_err++;
        rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? tog : ($urandom_range(0, 2) != 0);
        tog = !tog;
        if (rdy) begin
          e = {(LW-1)'(nout), cmem[nout % SS], cctl[nout % SS], (nout == drain_n - 1)};
          chk($sformatf("entry%0d", nout), 128'(w_snap), 128'(e));
          nout++;
          last_hs = cyc;
        end
        stalled = !rdy;
        prev = w_snap;
      end else begin
        rdy = 1'($urandom);
        if (w_snap != '0) idle_err++;
        stalled = 1'b0;
      end
      bus.out_ready = rdy;

      if (bus.in_ready) begin
        bus.in_valid = (vld_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        bus.in_data  = (idx < len) ? src[idx] : 8'($urandom);
        if (bus.in_valid) idx++;
      end else begin
        bus.in_valid = 1'($urandom);
        bus.in_data  = 8'($urandom);
      end
      if (start_in_load && bus.in_ready && !pulsed) begin
        bus.start   = 1'b1;
        bus.src_len = LW'($urandom_range(1, SS));
        pulsed      = 1'b1;
      end

      if (bus.job_done) begin
        done_cyc = cyc;
        chk("err_at_done", 128'(bus.job_err), 128'(exp_err));
      end

      if (rst_in_drain && bus.out_valid && nout == 2) begin
        #2 reset = 1'b1;
        #1;
        chk("async_reset_ctl", 128'({bus.busy, bus.job_done, bus.job_err, bus.in_ready,
            bus.core_clear, bus.core_valid, bus.out_valid, w_snap, bus.comp_len}), 128'(0));
        chk("async_reset_beat", bus.core_bytes, 128'(0));
        bus.in_valid = 1'b0; bus.core_done = 1'b0; bus.out_ready = 1'b0; bus.start = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        jd = 0; bz = 0;
        repeat (3) begin
          @(posedge clock); #1;
          if (bus.job_done) jd++;
          if (bus.busy) bz++;
        end
        chk("no_done_after_reset", 128'({jd, bz}), 128'(0));
        return;
      end

      if (done_cyc < 0) begin
        @(posedge clock); #1;
        cyc++;
      end
    end
    bus.core_done = 1'b0;
    bus.in_valid  = 1'b0;
    bus.start     = 1'b0;

    chk("job_done_seen", 128'(done_cyc >= 0), 128'(1));
    chk("clear_count", 128'(nclr), 128'(exp_beats > 0));
    chk("beat_count", 128'(nb), 128'(exp_beats));
    for (int b = 0; b < exp_beats && b < 8; b++)
      chk($sformatf("beat%0d", b), got[b], exp_beat(len, b));
    chk("comp_len", 128'(bus.comp_len), 128'(exp_clen));
    chk("drain_count", 128'(nout), 128'(drain_n));
    chk("busy_during_job", 128'(busy_err), 128'(0));
    chk("stall_stable", 128'(stall_err), 128'(0));
    chk("idle_out_zero", 128'(idle_err), 128'(0));
    if (exp_beats == 0) chk("reject_latency", 128'(done_cyc), 128'(1));
    if (exp_beats > 0) chk("first_in_ready", 128'(first_rdy), 128'(2));
    if (exp_beats > 0 && vld_mode == 0)
      chk("load_throughput", 128'(last_vld), 128'(1 + len + exp_beats));
    if (exp_beats > 0 && !give_done)
      chk("timeout_latency", 128'(done_cyc), 128'(last_vld + 1 + TO));
    if (drain_n > 0) begin
      chk("drain_start", 128'(first_out), 128'(done_at + 1));
      chk("done_after_last", 128'(done_cyc), 128'(last_hs + 1));
    end
    if (exp_beats > 0 && give_done && drain_n == 0)
      chk("empty_result_done", 128'(done_cyc), 128'(done_at + 1));
    repeat (2) begin
      @(posedge clock); #1;
      chk("idle_after_job", 128'({bus.busy, bus.job_done, bus.job_err, bus.in_ready,
          bus.core_valid, bus.out_valid}), 128'({1'b0, 1'b0, exp_err, 3'b000}));
    end
  endtask

  initial begin
    int len, cnt, rm, vm, beats;
    bit gd, err;
    nvec = 0;
    nmis = 0;
    //          len  cnt  gd rm vm err beats clen
    tbl[0] = '{ 20,   5, 1, 1, 0, 0,  2,    5 };
    tbl[1] = '{  0,   0, 0, 0, 0, 0,  0,    5 };
    tbl[2] = '{ 65,   0, 1, 0, 0, 1,  0,    5 };
    tbl[3] = '{ 16,   0, 1, 0, 0, 0,  1,    0 };
    tbl[4] = '{ 64, 100, 1, 2, 1, 0,  4,   64 };
    tbl[5] = '{ 33,   0, 0, 0, 0, 1,  3,   64 };
    tbl[6] = '{  1,   1, 1, 0, 1, 0,  1,    1 };
    tbl[7] = '{ 17,  64, 1, 2, 0, 0,  2,   64 };

    bus.start = 1'b0; bus.src_len = '0; bus.in_valid = 1'b0; bus.in_data = '0;
    bus.core_done = 1'b0; bus.core_count = '0; bus.out_ready = 1'b0;
    for (int i = 0; i < SS; i++) begin
      cmem[i] = '0;
      cctl[i] = 1'b0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_ctl", 128'({bus.busy, bus.job_done, bus.job_err, bus.in_ready, bus.core_clear,
        bus.core_valid, bus.out_valid, w_snap, bus.comp_len}), 128'(0));
    chk("reset_beat", bus.core_bytes, 128'(0));
    reset = 1'b0;
    @(posedge clock); #1;

    for (int r = 0; r < 8; r++)
      run_job(tbl[r].len, tbl[r].cnt, tbl[r].gd, tbl[r].rm, tbl[r].vm, tbl[r].err,
              tbl[r].beats, tbl[r].clen, 1'b0, 1'b0);

    // Start pulsed while loading must not disturb the running job.
    run_job(40, 3, 1'b1, 0, 1, 1'b0, 3, 3, 1'b1, 1'b0);
    // Reset in the middle of the drain aborts silently and clears comp_len.
    run_job(24, 10, 1'b1, 0, 0, 1'b0, 2, 10, 1'b0, 1'b1);
    run_job(5, 4, 1'b1, 1, 0, 1'b0, 1, 4, 1'b0, 1'b0);
    model_clen = 4;

    for (int j = 0; j < 12; j++) begin
      len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(SS + 1, 127))
                                        : int'($urandom_range(1, SS));
      cnt = int'($urandom_range(0, 80));
      gd  = ($urandom_range(0, 5) != 0);
      rm  = int'($urandom_range(0, 2));
      vm  = int'($urandom_range(0, 1));
      beats = (len > SS) ? 0 : (len + 15) / 16;
      err = (len > SS) || !gd;
      if (beats > 0 && gd) model_clen = (cnt > SS) ? SS : cnt;
      run_job(len, cnt, gd, rm, vm, err, beats, model_clen, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", nvec);
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire

// File: doc/lzrw1_job_sequencer.md
Name: lzrw1_job_sequencer

Overview:
Job-level controller that sequences one LZRW1 compression pass through the compressor core.
- Accepts a job start and a source length, then collects the source as a byte stream.
- Packs the stream into 16-byte beats and issues them to the core as valid pulses.
- Waits for core Done with a timeout, then drains the compressed bytes and their control bits as a handshaked output stream.
- Sits between the system byte source/sink and the compressor core; the core's wide result arrays are read through an external index mux.

Parameters:
STRINGSIZE, 4096, maximum source/compressed length in bytes; must be a power of two and at least 16.
TIMEOUT_CYCLES, 65536, cycles allowed in RUN for core Done before the job is flagged as failed.
LW, $clog2(STRINGSIZE)+1, length width (derived; not overridden).

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  job request; sampled only in IDLE
src_len  in  LW  source length in bytes, sampled with start
busy  out  1  high in every state except IDLE
job_done  out  1  one-cycle pulse at job end (success or error)
job_err  out  1  error flag; set at error, held until next accepted start
in_valid  in  1  source byte valid
in_data  in  8  source byte
in_ready  out  1  source byte accepted when in_valid && in_ready
core_clear  out  1  one-cycle core state clear at job start
core_valid  out  1  one-cycle beat-valid pulse to core
core_bytes  out  16x8  beat data; lane 0 holds the first byte
core_done  in  1  core end-of-string indication
core_count  in  32  number of compressed entries (core controlPtr)
core_rd_idx  out  LW-1  read index into the core compArray/controlWord
core_rd_byte  in  8  compArray[core_rd_idx], combinational
core_rd_ctl  in  1  controlWord[core_rd_idx], combinational
comp_len  out  LW  latched compressed length of the last job
out_valid  out  1  output entry valid
out_ready  in  1  downstream ready
out_data  out  8  = core_rd_byte while out_valid
out_ctl  out  1  = core_rd_ctl while out_valid
out_last  out  1  high with the final entry

Behaviour:
- Reset (async, any state): state=IDLE, and every output, counter, beat register and comp_len is 0. Reset mid-job aborts the job with no job_done pulse.
- States: IDLE, CLEAR, LOAD, ISSUE, RUN, DRAIN, FIN.
- IDLE:
  - start with src_len==0: go to FIN; job_err=0; no core activity.
  - start with src_len>STRINGSIZE: set job_err=1, go to FIN.
  - Otherwise: latch src_len, clear job_err, go to CLEAR.
- start in any state other than IDLE is ignored.
- CLEAR: core_clear=1 for exactly this cycle. Zero byte_cnt, lane_cnt and core_bytes. Go to LOAD.
- LOAD:
  - in_ready=1.
  - On handshake: core_bytes[lane_cnt]=in_data; lane_cnt+1; byte_cnt+1.
  - Go to ISSUE when lane_cnt reaches 16 or byte_cnt reaches src_len.
- ISSUE:
  - in_ready=0; core_valid=1 for one cycle carrying the current beat. Unfilled lanes are 0.
  - If byte_cnt==src_len: go to RUN and clear the timer.
  - Else: zero lane_cnt and core_bytes, return to LOAD.
- Load throughput is 16 bytes per 17 cycles at most.
- in_valid outside LOAD is ignored; no byte is consumed.
- RUN:
  - timer+1 per cycle.
  - core_done=1: latch comp_len=min(core_count, STRINGSIZE); set rd_idx=0. Go to DRAIN, or to FIN if comp_len==0.
  - timer==TIMEOUT_CYCLES-1 without core_done: set job_err=1, go to FIN.
  - core_done takes priority over timeout in the same cycle.
- DRAIN:
  - out_valid=1; out_last=(rd_idx==comp_len-1).
  - On out_valid && out_ready: rd_idx+1; after the last entry, go to FIN.
  - While out_valid && !out_ready, core_rd_idx, out_data, out_ctl and out_last are held stable.
  - Drain runs at 1 entry/cycle with out_ready held high.
- FIN: job_done=1 for one cycle; go to IDLE. busy drops the following cycle.
- core_rd_idx is 0 outside DRAIN. out_data, out_ctl and out_last are 0 when out_valid=0.
- Latency: start accepted at cycle 0 -> core_clear at cycle 1 -> in_ready at cycle 2.

Test Plan:
1. src_len=20, bytes 0x00..0x13, in_valid held high -> core_clear 1 cycle; first core_valid beat = 0x00..0x0F; second beat = 0x10..0x13 with lanes 4-15 = 0; exactly 2 core_valid pulses.
2. Core model returns Done with core_count=5, out_ready toggling 1010... -> 5 handshakes in rd_idx order 0..4; data stable while stalled; out_last only on entry 4; comp_len=5; job_done one cycle after the final handshake.
3. src_len=0 -> FIN, job_done pulse, job_err=0, no core_clear/core_valid. src_len=STRINGSIZE+1 -> job_err=1, job_done pulse, job_err held until the next start.
4. core_done never asserted, TIMEOUT_CYCLES=64 -> job_err=1 and job_done exactly 64 cycles after entering RUN; a subsequent valid job clears job_err.
5. start pulsed during LOAD, then reset asserted mid-DRAIN -> start ignored; all outputs 0 asynchronously on reset; no job_done; a new job runs correctly afterward.
